// File: rtl/alu_seq.sv
// Registered, handshaked LR35902-style ALU: one W-bit lane per cycle, optional
// second pass for 2W-bit register-pair ops, with a persistent {Z,N,H,C} flag register.
module alu_seq #(
    parameter int W      = 8,
    parameter bit EXT_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic           ext,
    input  logic [2*W-1:0] dest_data,
    input  logic [2*W-1:0] src_data,
    input  logic           flags_ld,
    input  logic [3:0]     flags_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] res,
    output logic [3:0]     flags
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP
    } op_e;

    state_e         r_state, w_state_nxt;
    op_e            r_op;
    logic           r_ext, r_cin, r_carry, r_lo_zero;
    logic [2*W-1:0] r_dest, r_src, r_res;
    logic [3:0]     r_flags;

    logic [W-1:0]   w_a, w_b, w_lane_val, w_lane_res;
    logic [W:0]     w_sum, w_diff;
    logic [4:0]     w_nib_sum, w_nib_diff;
    logic           w_cin, w_lane_c, w_lane_h, w_is_sub, w_is_arith;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign res       = r_res;
    assign flags     = r_flags;

    // One shared lane datapath; the HI pass chains the carry/borrow latched from LO.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_is_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
        w_is_arith = w_is_sub || (r_op == OP_ADD) || (r_op == OP_ADC);
        w_a        = (r_state == HI) ? r_dest[2*W-1:W] : r_dest[W-1:0];
        w_b        = (r_state == HI) ? r_src[2*W-1:W]  : r_src[W-1:0];
        if (r_state == HI)
            w_cin = w_is_arith & r_carry;
        else
            w_cin = ((r_op == OP_ADC) || (r_op == OP_SBC)) & r_cin;

        w_sum      = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};
        w_diff     = {1'b0, w_a} - {1'b0, w_b} - {{W{1'b0}}, w_cin};
        w_nib_sum  = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0, w_cin};
        w_nib_diff = {1'b0, w_a[3:0]} - {1'b0, w_b[3:0]} - {4'b0, w_cin};

        w_lane_val = '0;
        w_lane_c   = 1'b0;
        w_lane_h   = 1'b0;
        case (r_op)
            OP_ADD, OP_ADC: begin
                w_lane_val = w_sum[W-1:0];
                w_lane_c   = w_sum[W];
                w_lane_h   = w_nib_sum[4];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                w_lane_val = w_diff[W-1:0];
                w_lane_c   = w_diff[W];
                w_lane_h   = w_nib_diff[4];
            end
            OP_AND: begin
                w_lane_val = w_a & w_b;
                w_lane_h   = 1'b1;
            end
            OP_XOR:  w_lane_val = w_a ^ w_b;
            default: w_lane_val = w_a | w_b;
        endcase
        // CP keeps the left operand as its result; flags still come from the difference.
        w_lane_res = (r_op == OP_CP) ? w_a : w_lane_val;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = LO;
            LO:      w_state_nxt = r_ext ? HI : DONE;
            HI:      w_state_nxt = DONE;
            default: if (out_ready) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= OP_ADD;
            r_ext     <= 1'b0;
            r_cin     <= 1'b0;
            r_carry   <= 1'b0;
            r_lo_zero <= 1'b0;
            r_dest    <= '0;
            r_src     <= '0;
            r_res     <= '0;
            r_flags   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (flags_ld)
                        r_flags <= flags_in;
                    if (in_valid) begin
                        r_op   <= op_e'(op);
                        r_ext  <= ext & EXT_EN;
                        r_dest <= dest_data;
                        r_src  <= src_data;
                        r_cin  <= flags_ld ? flags_in[0] : r_flags[0];
                    end
                end
                LO: begin
                    r_res <= {{W{1'b0}}, w_lane_res};
                    if (r_ext) begin
                        r_carry   <= w_lane_c;
                        r_lo_zero <= (w_lane_val == '0);
                    end else begin
                        r_flags <= {(w_lane_val == '0), w_is_sub, w_lane_h, w_lane_c};
                    end
                end
                HI: begin
                    r_res[2*W-1:W] <= w_lane_res;
                    r_flags <= {r_lo_zero && (w_lane_val == '0), w_is_sub, w_lane_h, w_lane_c};
                end
                default: ;
            endcase
        end
    end

endmodule
